ibex_multdiv_iter: RTL
======================

Name: ibex_multdiv_iter

Overview:
- Iterative 32-bit multiply/divide unit for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage and owns no adder of its own.
- Each cycle it drives the ALU's 33-bit multdiv operand inputs and multdiv enable, then consumes the ALU's 34-bit extended adder result.
- Fixed-latency, single-outstanding-operation engine with a start/valid handshake towards the decoder/ID stage.

Parameters:
- None (data width fixed at 32).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  operation request; accepted only when ready_o=1
- kill_i  in  1  abort the current operation
- op_i  in  2  operation: 0=MULL, 1=MULH, 2=DIV, 3=REM
- signed_i  in  2  signedness: bit0 = operand a signed, bit1 = operand b signed
- op_a_i  in  32  operand a (multiplicand / dividend)
- op_b_i  in  32  operand b (multiplier / divisor)
- alu_adder_ext_i  in  34  ALU extended adder result
- alu_operand_a_o  out  33  to ALU multdiv operand a
- alu_operand_b_o  out  33  to ALU multdiv operand b
- multdiv_en_o  out  1  selects multdiv operands inside the ALU
- ready_o  out  1  idle, able to accept start_i
- valid_o  out  1  result_o valid (one-cycle pulse)
- result_o  out  32  result

Behaviour:
- Adder convention:
  - Every addition drives alu_operand_a_o={x,1} and alu_operand_b_o={y,c}.
  - The sum x+y+c is taken from alu_adder_ext_i[33:1] (33 bits).
  - Negation of x: x'=~x, y=0, c=1.
- multdiv_en_o = 1 in every state except IDLE and DONE; the operand outputs are 0 in those two states.
- Reset: state=IDLE, ready_o=1, valid_o=0, result_o=0, multdiv_en_o=0, all operand outputs 0.
- States and transitions: IDLE -> ABS_A -> ABS_B -> CALC (32 cycles, 5-bit counter 31..0) -> FIX -> DONE -> IDLE. Every state is always traversed.
- Latency: start_i is sampled high in IDLE at cycle 0; valid_o=1 in cycle 36 for exactly one cycle; ready_o returns to 1 in cycle 37.
- IDLE:
  - On start_i, latch op_i, signed_i, op_a_i and op_b_i.
  - ready_o=0 from the next cycle.
- ABS_A / ABS_B: each operand is replaced by its magnitude via the adder if it is signed and its bit31=1; otherwise it passes through unchanged.
- Record the result sign:
  - Multiplication: sa^sb.
  - DIV: sa^sb, forced to 0 when the divisor is 0.
  - REM: sa.
- CALC, multiply:
  - 64-bit product {hi,lo} starts with hi=0, lo=|b|.
  - Each cycle, sum = hi + (lo[0] ? |a| : 0); then {hi,lo} = {sum[32:0],lo[31:1]} shifted right by one, so the carry is kept.
- CALC, divide (restoring):
  - Initial state: rem=0, quo=|a|.
  - Each cycle: shifted remainder s = {rem, quo[31]} (33 bits); trial difference d = s[31:0] - |b| (33-bit sum via ~|b| with c=1).
  - keep = s[32] | ~d[32].
  - If keep: rem=d[31:0]; otherwise rem=s[31:0].
  - quo = {quo[30:0], keep}.
- FIX: if the recorded sign is 1, negate the selected word via the adder; otherwise pass it through. The selected word is:
  - MULL: lo.
  - MULH: ~hi + (lo==0) (c=(lo==0)).
  - DIV: quo.
  - REM: rem.
- DONE: result_o registered; valid_o=1.
- result_o holds its last value until the next DONE.
- Required boundary results:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
  - These results must fall out of the algorithm; no special-case result path.
- start_i while ready_o=0 is ignored.
- kill_i:
  - In any non-IDLE state, kill_i returns the block to IDLE next cycle; valid_o is not asserted and result_o is unchanged.
  - kill_i in DONE suppresses nothing, because valid_o is already high that cycle.
  - kill_i and start_i together in IDLE: start wins.
- rst_i mid-operation: IDLE next cycle, with all outputs at reset values.

Test Plan:
- MULL unsigned, a=0x0000FFFF, b=0x00010001 -> valid_o at cycle 36, result_o=0xFFFFFFFF; ready_o low cycles 1..36.
- MULH signed/signed, a=0xFFFFFFFE (-2), b=0x00000003 -> 0xFFFFFFFF; MULHU same operands -> 0x00000002; MULH signed a, unsigned b (MULHSU), a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
- DIV signed, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV a=0xFFFFFFF9, b=0 -> 0xFFFFFFFF; REM -> 0xFFFFFFF9. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- kill_i asserted at cycle 10 of a DIV -> no valid_o, ready_o=1 at cycle 11. A new MULL 3*5 started at cycle 11 -> result_o=15 at cycle 47.
- rst_i at cycle 20 of a MUL -> outputs at reset values from cycle 21; start_i high during cycle 20 ignored; back-to-back starts at cycles 0 and 37 both complete, at cycles 36 and 73.

Source files
------------

// File: rtl/ibex_multdiv_iter.sv
// rtl/ibex_multdiv_iter.sv - iterative RV32M multiply/divide engine sharing the ALU adder
module ibex_multdiv_iter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [1:0]  op_i,
  input  logic [1:0]  signed_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        multdiv_en_o,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, CALC, FIX, DONE} state_e;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  state_e      state_q, state_d;
  logic [1:0]  op_q, signed_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, result_q;
  logic        neg_q;
  logic [4:0]  cnt_q;

  logic [31:0] add_x, add_y, fix_w, div_s;
  logic        add_c, is_mul, keep, sa_in, sb_in;
  logic [32:0] sum;
  logic        unused_ext0;

  // The ALU adds {x,1}+{y,c}, so bits [33:1] hold x+y+c.
  assign sum         = alu_adder_ext_i[33:1];
  assign unused_ext0 = alu_adder_ext_i[0];

  assign is_mul = ~op_q[1];
  assign sa_in  = signed_i[0] & op_a_i[31];
  assign sb_in  = signed_i[1] & op_b_i[31];

  // Restoring division: shifted remainder is {rem, quo[31]}; adder carry-out means no borrow.
  assign div_s = {hi_q[30:0], lo_q[31]};
  assign keep  = hi_q[31] | sum[32];

  assign result_o = result_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed walk through every state; kill aborts anything but IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ABS_A;
      ABS_A:   state_d = ABS_B;
      ABS_B:   state_d = CALC;
      CALC:    if (cnt_q == 5'd0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i && state_q != IDLE) state_d = IDLE;
  end

  // Outputs: handshake flags and the adder operands for the current step
  always_comb begin
    ready_o         = (state_q == IDLE);
    valid_o         = (state_q == DONE);
    multdiv_en_o    = (state_q != IDLE) && (state_q != DONE);
    add_x           = '0;
    add_y           = '0;
    add_c           = 1'b0;
    fix_w           = '0;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    case (state_q)
      ABS_A: begin
        add_c = signed_q[0] & a_q[31];
        add_x = add_c ? ~a_q : a_q;
      end
      ABS_B: begin
        add_c = signed_q[1] & b_q[31];
        add_x = add_c ? ~b_q : b_q;
      end
      CALC: begin
        if (is_mul) begin
          add_x = hi_q;
          add_y = lo_q[0] ? a_q : '0;
        end else begin
          add_x = div_s;
          add_y = ~b_q;
          add_c = 1'b1;
        end
      end
      FIX: begin
        case (op_q)
          OP_MULL: fix_w = lo_q;
          OP_MULH: fix_w = hi_q;
          OP_DIV:  fix_w = lo_q;
          default: fix_w = hi_q;
        endcase
        add_x = neg_q ? ~fix_w : fix_w;
        // Negating the high word of a 64-bit product only carries in when the low word is zero
        if (op_q == OP_MULH) add_c = neg_q & (lo_q == '0);
        else                 add_c = neg_q;
      end
      default: ;
    endcase
    if (multdiv_en_o) begin
      alu_operand_a_o = {add_x, 1'b1};
      alu_operand_b_o = {add_y, add_c};
    end
  end

  // Datapath: operand latch, magnitudes, shift/add iterations and final result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= '0;
      signed_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            signed_q <= signed_i;
            a_q      <= op_a_i;
            b_q      <= op_b_i;
            if (op_i == OP_REM)      neg_q <= sa_in;
            else if (op_i == OP_DIV) neg_q <= (sa_in ^ sb_in) & (op_b_i != '0);
            else                     neg_q <= sa_in ^ sb_in;
          end
        end
        ABS_A: a_q <= sum[31:0];
        ABS_B: begin
          b_q   <= sum[31:0];
          hi_q  <= '0;
          lo_q  <= is_mul ? sum[31:0] : a_q;
          cnt_q <= 5'd31;
        end
        CALC: begin
          cnt_q <= cnt_q - 5'd1;
          if (is_mul) begin
            hi_q <= sum[32:1];
            lo_q <= {sum[0], lo_q[31:1]};
          end else begin
            hi_q <= keep ? sum[31:0] : div_s;
            lo_q <= {lo_q[30:0], keep};
          end
        end
        FIX: if (!kill_i) result_q <= sum[31:0];
        default: ;
      endcase
    end
  end

endmodule
